// File: rtl/tanh_lut_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tanh_lut_fetch
// Purpose  : Front stage of the LSTM tanh activation unit. Splits a signed
//            Q4.4 sample into an integer table index and a 4-bit fraction.
//            Fetches the two bracketing entries of a 17-entry tanh table and
//            presents base / next_data / change / remaining to the linear
//            interpolator. This is a 2-stage ready/valid pipeline, so it
//            stalls cleanly under backpressure.
// Ports    : clk        rising-edge clock
//            rst        asynchronous reset, active low
//            in_valid   x_in carries a sample
//            in_ready   sample accepted this cycle
//            x_in       signed Q4.4 sample
//            out_valid  output bundle valid
//            out_ready  interpolator accepts the bundle
//            base       T(idx), signed Q4.4
//            next_data  T(idx+1), signed Q4.4
//            change     next_data - base
//            remaining  fraction x_in[3:0], zero-extended
// Revision : 1.0 - initial release
// ============================================================================
module tanh_lut_fetch #(
  parameter int WIDTH = 8,
  parameter int FRAC  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] base,
  output logic [WIDTH-1:0] next_data,
  output logic [WIDTH-1:0] change,
  output logic [WIDTH-1:0] remaining
);

  // round(16*tanh(k)) in Q4.4
  localparam logic [WIDTH-1:0] c_m16 = 8'hF0;
  localparam logic [WIDTH-1:0] c_m15 = 8'hF1;
  localparam logic [WIDTH-1:0] c_m12 = 8'hF4;
  localparam logic [WIDTH-1:0] c_zero = 8'h00;
  localparam logic [WIDTH-1:0] c_p12 = 8'h0C;
  localparam logic [WIDTH-1:0] c_p15 = 8'h0F;
  localparam logic [WIDTH-1:0] c_p16 = 8'h10;

  // Table lookup over k = -8..8. The index is carried one bit wider than the
  // Q4.4 integer part so that idx+1 = 8 is representable. Everything outside
  // -2..2 is saturated, and the sign bit picks the saturation rail.
  function automatic logic [WIDTH-1:0] tanh_tab(input logic signed [4:0] k);
    logic [WIDTH-1:0] v;
    v = c_zero;
    case (k)
      -5'sd2:  v = c_m15;
      -5'sd1:  v = c_m12;
      5'sd0:   v = c_zero;
      5'sd1:   v = c_p12;
      5'sd2:   v = c_p15;
      default: v = k[4] ? c_m16 : c_p16;
    endcase
    return v;
  endfunction

  logic                    r_s1_valid;
  logic [WIDTH-FRAC-1:0]   r_idx;
  logic [FRAC-1:0]         r_frac;
  logic                    r_s2_valid;
  logic [WIDTH-1:0]        r_base;
  logic [WIDTH-1:0]        r_next;
  logic [WIDTH-1:0]        r_change;
  logic [WIDTH-1:0]        r_rem;

  logic                    w_adv1;
  logic                    w_adv2;
  logic signed [4:0]       w_k0;
  logic signed [4:0]       w_k1;
  logic [WIDTH-1:0]        w_base;
  logic [WIDTH-1:0]        w_next;

  // S2 takes S1 whenever it is empty or being drained in the same cycle. The
  // in_ready path is combinational from out_ready, so a full pipe that is
  // draining keeps accepting every cycle without a skid buffer.
  assign w_adv2   = r_s1_valid && (!r_s2_valid || out_ready);
  assign in_ready = !r_s1_valid || w_adv2;
  assign w_adv1   = in_valid && in_ready;

  assign w_k0   = {r_idx[WIDTH-FRAC-1], r_idx};
  assign w_k1   = w_k0 + 5'sd1;
  assign w_base = tanh_tab(w_k0);
  assign w_next = tanh_tab(w_k1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_idx      <= '0;
      r_frac     <= '0;
    end else begin
      if (w_adv1) begin
        r_s1_valid <= 1'b1;
        r_idx      <= x_in[WIDTH-1:FRAC];
        r_frac     <= x_in[FRAC-1:0];
      end else if (w_adv2) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s2_valid <= 1'b0;
      r_base     <= '0;
      r_next     <= '0;
      r_change   <= '0;
      r_rem      <= '0;
    end else begin
      if (w_adv2) begin
        r_s2_valid <= 1'b1;
        r_base     <= w_base;
        r_next     <= w_next;
        // Adjacent entries differ by at most 12, so the 8-bit wrap-around
        // difference equals the truncated 9-bit signed difference.
        r_change   <= w_next - w_base;
        r_rem      <= {{(WIDTH-FRAC){1'b0}}, r_frac};
      end else if (r_s2_valid && out_ready) begin
        r_s2_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign base      = r_base;
  assign next_data = r_next;
  assign change    = r_change;
  assign remaining = r_rem;

endmodule
`default_nettype wire

// File: tb/tb_tanh_lut_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_tanh_lut_fetch
// Purpose  : Directed and randomised self-checking bench for tanh_lut_fetch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tanh_lut_fetch;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] x_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] base;
  logic [7:0] next_data;
  logic [7:0] change;
  logic [7:0] remaining;
  logic [31:0] bundle;

  int checks = 0;
  int errors = 0;

  tanh_lut_fetch #(.WIDTH(8), .FRAC(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .base      (base),
    .next_data (next_data),
    .change    (change),
    .remaining (remaining)
  );

  assign bundle = {base, next_data, change, remaining};

  always #5 clk = ~clk;

  // Reference table: round(16*tanh(k))
  function automatic int tab(input int k);
    if (k <= -3) return -16;
    if (k == -2) return -15;
    if (k == -1) return -12;
    if (k == 0)  return 0;
    if (k == 1)  return 12;
    if (k == 2)  return 15;
    return 16;
  endfunction

  function automatic logic [31:0] model(input logic [7:0] x);
    int k;
    int b;
    int n;
    logic [7:0] b8;
    logic [7:0] n8;
    logic [7:0] c8;
    k  = int'($signed(x[7:4]));
    b  = tab(k);
    n  = tab(k + 1);
    b8 = 8'(b);
    n8 = 8'(n);
    c8 = 8'(n - b);
    return {b8, n8, c8, 4'h0, x[3:0]};
  endfunction

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (bundle !== 32'h0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 00000000", bundle);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    // fill the pipe, then assert reset between clock edges
    in_valid = 1'b1; x_in = 8'h18; out_ready = 1'b0;
    @(negedge clk);
    x_in = 8'h28;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || base !== 8'h0C) begin
      errors++; $display("FAIL midstream_fill: got valid=%b base=%h expected 1/0c", out_valid, base);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || bundle !== 32'h0) begin
      errors++; $display("FAIL midstream_reset: got valid=%b bundle=%h expected 0/00000000", out_valid, bundle);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_single(input logic [7:0] x, input logic [7:0] eb,
                             input logic [7:0] en, input logic [7:0] ec,
                             input logic [7:0] er);
    @(negedge clk);
    in_valid = 1'b1; x_in = x; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL single_in_ready x=%h: got %b expected 1", x, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL single_early x=%h: got out_valid=%b expected 0", x, out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL single_valid x=%h: got %b expected 1", x, out_valid);
    end
    checks++;
    if (bundle !== {eb, en, ec, er}) begin
      errors++; $display("FAIL single_data x=%h: got %h expected %h", x, bundle, {eb, en, ec, er});
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL single_pop x=%h: got out_valid=%b expected 0", x, out_valid);
    end
  endtask

  task automatic test_sweep;
    logic [7:0] xe;
    for (int c = 0; c < 258; c++) begin
      @(negedge clk);
      in_valid = (c < 256); x_in = 8'(c); out_ready = 1'b1;
      #1;
      if (c < 256) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++; $display("FAIL sweep_in_ready c=%0d: got %b expected 1", c, in_ready);
        end
      end
      checks++;
      if (c >= 2) begin
        xe = 8'(c - 2);
        if (out_valid !== 1'b1 || bundle !== model(xe)) begin
          errors++; $display("FAIL sweep_out x=%h: got valid=%b %h expected 1 %h", xe, out_valid, bundle, model(xe));
        end
      end else if (out_valid !== 1'b0) begin
        errors++; $display("FAIL sweep_lead c=%0d: got out_valid=%b expected 0", c, out_valid);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL sweep_drain: got out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] smp [4];
    int ptr;
    int got;
    smp[0] = 8'h00; smp[1] = 8'h10; smp[2] = 8'h20; smp[3] = 8'h30;
    ptr = 0; got = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      in_valid  = (ptr < 4);
      x_in      = smp[ptr < 4 ? ptr : 3];
      out_ready = (c < 2) || (c >= 8);
      #1;
      if (c >= 2 && c < 8) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++; $display("FAIL bp_in_ready c=%0d: got %b expected 0", c, in_ready);
        end
        checks++;
        if (out_valid !== 1'b1 || base !== 8'h00 || next_data !== 8'h0C) begin
          errors++; $display("FAIL bp_frozen c=%0d: got valid=%b base=%h next=%h expected 1/00/0c", c, out_valid, base, next_data);
        end
      end
      if (c == 7) begin
        checks++;
        if (ptr !== 2) begin
          errors++; $display("FAIL bp_accepted: got %0d expected 2", ptr);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (got >= 4) begin
          errors++; $display("FAIL bp_extra: got extra output %h expected none", bundle);
        end else if (bundle !== model(smp[got])) begin
          errors++; $display("FAIL bp_order n=%0d: got %h expected %h", got, bundle, model(smp[got]));
        end
        got++;
      end
      if (in_valid && in_ready) ptr++;
    end
    in_valid = 1'b0;
    checks++;
    if (got !== 4) begin
      errors++; $display("FAIL bp_count: got %0d expected 4", got);
    end
  endtask

  task automatic test_random;
    logic [7:0] q[$];
    logic hold;
    hold = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if (!hold) begin
        in_valid = 1'($urandom_range(0, 1));
        x_in     = 8'($urandom);
      end
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand_spurious c=%0d: got %h expected no output", c, bundle);
        end else if (bundle !== model(q[0])) begin
          errors++; $display("FAIL rand_data c=%0d: got %h expected %h", c, bundle, model(q[0]));
        end
        if (out_ready && q.size() > 0) void'(q.pop_front());
      end
      if (in_valid && in_ready) q.push_back(x_in);
      hold = in_valid && !in_ready;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (out_valid) begin
        checks++;
        if (q.size() == 0 || bundle !== model(q[0])) begin
          errors++; $display("FAIL rand_drain: got %h expected %h", bundle, q.size() ? model(q[0]) : 32'h0);
        end
        if (q.size() > 0) void'(q.pop_front());
      end
      @(negedge clk);
    end
    checks++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rand_left: got %0d pending valid=%b expected 0/0", q.size(), out_valid);
    end
  endtask

  task automatic test_reset_mid_stall;
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b0; x_in = 8'h18;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (!in_ready) break;
      @(negedge clk);
      x_in = x_in + 8'h10;
    end
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL stall_fill: got in_ready=%b out_valid=%b expected 0/1", in_ready, out_valid);
    end
    in_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || bundle !== 32'h0) begin
      errors++; $display("FAIL stall_reset: got valid=%b bundle=%h expected 0/00000000", out_valid, bundle);
    end
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL stall_release: got in_ready=%b expected 1", in_ready);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL stall_stale c=%0d: got out_valid=%b expected 0", c, out_valid);
      end
    end
    test_single(8'hE8, 8'hF1, 8'hF4, 8'h03, 8'h08);
  endtask

  initial begin
    clk = 1'b0; rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x_in = 8'h00;
    test_reset;
    test_single(8'h18, 8'h0C, 8'h0F, 8'h03, 8'h08);
    test_single(8'hF0, 8'hF4, 8'h00, 8'h0C, 8'h00);
    test_single(8'h80, 8'hF0, 8'hF0, 8'h00, 8'h00);
    test_single(8'h7F, 8'h10, 8'h10, 8'h00, 8'h0F);
    test_sweep;
    test_backpressure;
    test_random;
    test_reset_mid_stall;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
